// File: rtl/opl2_cmd_recorder.sv
// OPL2 register-write recorder: timestamps each write and buffers player-format words in a FIFO.
// Optional OPL3 bank capture (9-bit address, 15-bit delay) via `define OPL2_CMD_RECORDER_BANK_EN.
module opl2_cmd_recorder #(
  parameter int FIFO_AW      = 9,
  parameter int PRESCALE_MAX = 99999
) (
  input  logic               Bus2IP_Clk,
  input  logic               Bus2IP_Resetn,
  input  logic               rec_en,
  input  logic               ev_we,
`ifdef OPL2_CMD_RECORDER_BANK_EN
  input  logic [8:0]         ev_adr,
`else
  input  logic [7:0]         ev_adr,
`endif
  input  logic [7:0]         ev_data,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               empty,
  output logic               half_full,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               lost,
  input  logic               clr_lost,
  output logic               irq
);

`ifdef OPL2_CMD_RECORDER_BANK_EN
  localparam int ADR_W = 9;
  localparam int DLY_W = 15;
`else
  localparam int ADR_W = 8;
  localparam int DLY_W = 16;
`endif

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_HALF = (FIFO_AW+1)'(DEPTH / 2);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [16:0]      PRESC_TC = 17'(PRESCALE_MAX);
  localparam logic [DLY_W-1:0] DLY_MAX  = '1;
  localparam logic [DLY_W-1:0] DLY_PRE  = DLY_MAX - 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_push;
  logic               w_flush;

  logic [16:0]        r_presc;
  logic [DLY_W-1:0]   r_elapsed;
  logic [ADR_W-1:0]   r_pend_adr;
  logic [7:0]         r_pend_data;
  logic               w_run;
  logic               w_tick;
  logic               w_sat_hit;
  logic [DLY_W-1:0]   w_delay;
  logic [DLY_W-1:0]   w_dly_field;
  logic [31:0]        w_word;

  logic [31:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW-1:0] w_rptr_nxt;
  logic [FIFO_AW:0]   r_level;
  logic [FIFO_AW:0]   w_level_nxt;
  logic               r_empty;
  logic               r_full;
  logic               r_half;
  logic               r_lost;
  logic [31:0]        r_rd_data;
  logic [31:0]        w_head_nxt;
  logic               w_wr;
  logic               w_pop;
  logic               w_drop;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Each write waits in the pending register until the next write tells us its delay.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rec_en) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!rec_en) begin
          w_state_nxt = S_IDLE;
        end else if (ev_we) begin
          w_load      = 1'b1;
          w_state_nxt = S_TIMING;
        end
      end
      S_TIMING: begin
        if (!rec_en) begin
          w_state_nxt = S_FLUSH;
        end else if (ev_we) begin
          w_load = 1'b1;
          w_push = 1'b1;
        end
      end
      S_FLUSH: begin
        w_push      = 1'b1;
        w_flush     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_run     = (r_state == S_TIMING) && rec_en;
  assign w_tick    = w_run && (r_presc == PRESC_TC);
  assign w_sat_hit = w_tick && (r_elapsed == DLY_PRE);
  // A tick landing on the same edge as the next write still counts toward this word.
  assign w_delay     = (w_tick && (r_elapsed != DLY_MAX)) ? r_elapsed + 1'b1 : r_elapsed;
  assign w_dly_field = w_flush ? '0 : w_delay;

`ifdef OPL2_CMD_RECORDER_BANK_EN
  assign w_word = {r_pend_adr[8], w_dly_field, r_pend_adr[7:0], r_pend_data};
`else
  assign w_word = {w_dly_field, r_pend_adr, r_pend_data};
`endif

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)       r_presc <= '0;
    else if (!w_run || w_load) r_presc <= '0;
    else if (w_tick)           r_presc <= '0;
    else                       r_presc <= r_presc + 1'b1;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)                         r_elapsed <= '0;
    else if (w_load)                            r_elapsed <= '0;
    else if (w_tick && (r_elapsed != DLY_MAX))  r_elapsed <= r_elapsed + 1'b1;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_pend_adr  <= '0;
      r_pend_data <= '0;
    end else if (w_load) begin
      r_pend_adr  <= ev_adr;
      r_pend_data <= ev_data;
    end
  end

  // When full, a push is only accepted if a pop frees the slot in the same cycle.
  assign w_pop      = rd_en && !r_empty;
  assign w_wr       = w_push && (!r_full || rd_en);
  assign w_drop     = w_push && r_full && !rd_en;
  assign w_rptr_nxt = w_pop ? r_rptr + 1'b1 : r_rptr;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop)      w_level_nxt = r_level + 1'b1;
    else if (!w_wr && w_pop) w_level_nxt = r_level - 1'b1;
  end

  always_comb begin
    w_head_nxt = r_rd_data;
    if (w_level_nxt == '0)
      w_head_nxt = '0;
    else if (w_wr && ((r_level == '0) || (w_pop && (r_level == LVL_ONE))))
      w_head_nxt = w_word;
    else if (w_pop)
      w_head_nxt = r_mem[w_rptr_nxt];
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_half    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      r_rptr    <= w_rptr_nxt;
      r_level   <= w_level_nxt;
      r_empty   <= (w_level_nxt == '0);
      r_full    <= (w_level_nxt == LVL_FULL);
      r_half    <= (w_level_nxt >= LVL_HALF);
      r_rd_data <= w_head_nxt;
    end
  end

  // Clearing wins over a same-cycle drop or saturation.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn)           r_lost <= 1'b0;
    else if (clr_lost)            r_lost <= 1'b0;
    else if (w_drop || w_sat_hit) r_lost <= 1'b1;
  end

  assign rd_data   = r_rd_data;
  assign empty     = r_empty;
  assign half_full = r_half;
  assign full      = r_full;
  assign level     = r_level;
  assign lost      = r_lost;
  assign irq       = r_half & rec_en;

endmodule

// File: tb/tb_opl2_cmd_recorder.sv
// Directed self-checking bench for opl2_cmd_recorder (default build, 8-bit address).
// Instance A uses a 5-clock ms tick; instance B uses a 1-clock tick to reach delay saturation quickly.
module tb_opl2_cmd_recorder;

  logic        clk;
  logic        rstn;
  logic        rec_en;
  logic        ev_we;
  logic [7:0]  ev_adr;
  logic [7:0]  ev_data;
  logic        rd_en;
  logic        clr_lost;

  logic [31:0] rdDataA, rdDataB;
  logic        emptyA, emptyB, halfA, halfB, fullA, fullB, lostA, lostB, irqA, irqB;
  logic [2:0]  levelA, levelB;

  int nChecks = 0;
  int nFails  = 0;

  opl2_cmd_recorder #(.FIFO_AW(2), .PRESCALE_MAX(4)) dutA (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstn), .rec_en(rec_en), .ev_we(ev_we),
    .ev_adr(ev_adr), .ev_data(ev_data), .rd_en(rd_en), .rd_data(rdDataA),
    .empty(emptyA), .half_full(halfA), .full(fullA), .level(levelA),
    .lost(lostA), .clr_lost(clr_lost), .irq(irqA)
  );

  opl2_cmd_recorder #(.FIFO_AW(2), .PRESCALE_MAX(0)) dutB (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstn), .rec_en(rec_en), .ev_we(ev_we),
    .ev_adr(ev_adr), .ev_data(ev_data), .rd_en(rd_en), .rd_data(rdDataB),
    .empty(emptyB), .half_full(halfB), .full(fullB), .level(levelB),
    .lost(lostB), .clr_lost(clr_lost), .irq(irqB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one cycle of write/pop strobes, returning just after the sampling edge.
  task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [7:0] dat, input logic rd);
    ev_we   = we;
    ev_adr  = adr;
    ev_data = dat;
    rd_en   = rd;
    @(posedge clk);
    #1;
    ev_we = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; rec_en = 1'b0; ev_we = 1'b0; ev_adr = '0; ev_data = '0;
    rd_en = 1'b0; clr_lost = 1'b0;
    idle(3);
    checkOutput("rst_empty", 32'(emptyA), 32'd1);
    checkOutput("rst_full", 32'(fullA), 32'd0);
    checkOutput("rst_half", 32'(halfA), 32'd0);
    checkOutput("rst_level", 32'(levelA), 32'd0);
    checkOutput("rst_rd_data", rdDataA, 32'h0);
    checkOutput("rst_lost", 32'(lostA), 32'd0);
    checkOutput("rst_irq", 32'(irqA), 32'd0);
    rstn = 1'b1;
    idle(1);

    $display("[TB] two writes 3 ms apart then flush");
    rec_en = 1'b1;
    idle(1);
    applyStimulus(1'b1, 8'h20, 8'h01, 1'b0);
    idle(14);
    applyStimulus(1'b1, 8'hA0, 8'h44, 1'b0);
    checkOutput("t1_word0", rdDataA, 32'h0003_2001);
    checkOutput("t1_level1", 32'(levelA), 32'd1);
    checkOutput("t1_not_empty", 32'(emptyA), 32'd0);
    rec_en = 1'b0;
    idle(2);
    checkOutput("t1_level2", 32'(levelA), 32'd2);
    checkOutput("t1_head_held", rdDataA, 32'h0003_2001);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_word1", rdDataA, 32'h0000_A044);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t1_drained", 32'(emptyA), 32'd1);
    checkOutput("t1_drained_rd", rdDataA, 32'h0);

    $display("[TB] back-to-back writes");
    rec_en = 1'b1;
    idle(1);
    applyStimulus(1'b1, 8'h11, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 8'h44, 1'b0);
    checkOutput("t2_zero_delay", rdDataA, 32'h0000_1122);
    rec_en = 1'b0;
    idle(2);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t2_flush_word", rdDataA, 32'h0000_3344);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t2_drained", 32'(levelA), 32'd0);

    $display("[TB] overflow, clear, push+pop while full");
    rec_en = 1'b1;
    idle(1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'h40 + k), 8'(k), 1'b0);
    checkOutput("t3_level", 32'(levelA), 32'd4);
    checkOutput("t3_full", 32'(fullA), 32'd1);
    checkOutput("t3_half", 32'(halfA), 32'd1);
    checkOutput("t3_irq", 32'(irqA), 32'd1);
    checkOutput("t3_lost", 32'(lostA), 32'd1);
    checkOutput("t3_head", rdDataA, 32'h0000_4000);
    clr_lost = 1'b1;
    idle(1);
    clr_lost = 1'b0;
    checkOutput("t3_clr_lost", 32'(lostA), 32'd0);
    applyStimulus(1'b1, 8'h46, 8'h06, 1'b1);
    checkOutput("t4_level", 32'(levelA), 32'd4);
    checkOutput("t4_full", 32'(fullA), 32'd1);
    checkOutput("t4_lost", 32'(lostA), 32'd0);
    checkOutput("t4_head", rdDataA, 32'h0000_4101);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("t4_level3", 32'(levelA), 32'd3);
    checkOutput("t4_head2", rdDataA, 32'h0000_4202);

    $display("[TB] asynchronous reset mid-recording");
    rstn = 1'b0;
    #2;
    checkOutput("t5_empty", 32'(emptyA), 32'd1);
    checkOutput("t5_level", 32'(levelA), 32'd0);
    checkOutput("t5_rd_data", rdDataA, 32'h0);
    checkOutput("t5_full", 32'(fullA), 32'd0);
    idle(2);
    rstn = 1'b1;
    idle(2);
    rec_en = 1'b0;
    idle(3);
    checkOutput("t5_no_flush_empty", 32'(emptyA), 32'd1);
    checkOutput("t5_no_flush_level", 32'(levelA), 32'd0);

    $display("[TB] long pending write saturates delay");
    rec_en = 1'b1;
    idle(1);
    applyStimulus(1'b1, 8'h55, 8'h66, 1'b0);
    idle(70000);
    applyStimulus(1'b1, 8'h77, 8'h88, 1'b0);
    checkOutput("t6_a_delay", rdDataA, 32'h36B0_5566);
    checkOutput("t6_a_lost", 32'(lostA), 32'd0);
    checkOutput("t6_b_sat_word", rdDataB, 32'hFFFF_5566);
    checkOutput("t6_b_lost", 32'(lostB), 32'd1);
    clr_lost = 1'b1;
    idle(1);
    clr_lost = 1'b0;
    checkOutput("t6_b_clr_lost", 32'(lostB), 32'd0);
    rec_en = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
